// File: rtl/ref_bank_mem_p.sv
// ---------------------------------------------------------------------------
// ref_bank_mem_p
//
// Banked reference-window memory for the motion-estimation datapath.
// NBANK independent banks, each DEPTH words deep. A word holds one pixel
// column of ROWS pixels (pixel r = row r). Writes are broadcast from a
// lane-interleaved bus to any subset of banks (bank j takes lane j%LANES).
// Reads return either a whole NBANK x ROWS block, a single row, or a row
// burst that walks one block out as ROWS single-row beats. The output stage
// honours back-pressure so the SAD array can stall freely.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-HIGH despite its name
//   wr_en        write strobe
//   wr_bank_sel  one bit per bank, 1 = write that bank
//   wr_addr      word address shared by all selected banks
//   wr_data      LANES lanes of ROWS*PIXEL bits, lane 0 in the LSBs
//   rd_valid     read request valid
//   rd_ready     read request accepted when rd_valid && rd_ready
//   rd_addr      read word address (out-of-range reads return zeros)
//   rd_mode      0 block, 1 single row, 2 row burst, 3 behaves as 0
//   rd_row       row index for single-row reads
//   out_data     block: row r at [r*NBANK*PIXEL +: NBANK*PIXEL];
//                row modes: low NBANK*PIXEL bits, upper bits zero
//   out_valid    out_data valid
//   out_ready    consumer accepts when out_valid && out_ready
//   out_row      row index of the current beat (0 for block reads)
//   out_last     final beat of the request
// ---------------------------------------------------------------------------
module ref_bank_mem_p #(
    parameter int PIXEL = 8,
    parameter int NBANK = 32,
    parameter int ROWS  = 8,
    parameter int DEPTH = 96,
    parameter int AW    = 7,
    parameter int LANES = 4,
    parameter int RW    = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [NBANK-1:0]            wr_bank_sel,
    input  logic [AW-1:0]               wr_addr,
    input  logic [LANES*ROWS*PIXEL-1:0] wr_data,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [AW-1:0]               rd_addr,
    input  logic [1:0]                  rd_mode,
    input  logic [RW-1:0]               rd_row,
    output logic [NBANK*ROWS*PIXEL-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RW-1:0]               out_row,
    output logic                        out_last
);

    localparam int WORD_W = ROWS * PIXEL;
    localparam int ROW_W  = NBANK * PIXEL;
    localparam int BLK_W  = NBANK * WORD_W;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    localparam logic [1:0] MODE_BLOCK = 2'd0;
    localparam logic [1:0] MODE_ROW   = 2'd1;
    localparam logic [1:0] MODE_BURST = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    // Address range check; out-of-range writes are dropped and
    // out-of-range reads return zeros.
    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // Collapse rd_mode 3 onto block mode so downstream only sees 0/1/2.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_BLOCK : m;
    endfunction

    logic                accept;
    logic                wr_in_range;
    logic                rd_in_range;
    logic                adv2;
    logic                s1_free;

    logic                vld_p1;
    logic [1:0]          mode_p1;
    logic [RW-1:0]       row_p1;
    logic [BLK_W-1:0]    words_p1;   // bank-major: bank j word at [j*WORD_W +: WORD_W]
    logic [BLK_W-1:0]    block_p1;   // row-major output layout
    logic [RW-1:0]       sel_row;
    logic [ROW_W-1:0]    row_sel_data;

    state_t              state, state_nxt;
    logic [RW-1:0]       cnt, cnt_nxt;
    logic                valid_nxt;
    logic                last_nxt;
    logic [RW-1:0]       row_nxt;
    logic [BLK_W-1:0]    data_nxt;

    assign wr_in_range = addr_in_range(wr_addr);
    assign rd_in_range = addr_in_range(rd_addr);
    assign adv2        = !out_valid || out_ready;

    // rd_ready is forced low while reset is held so nothing is accepted
    // into a pipeline that is being cleared.
    assign rd_ready = !rst_n && (!vld_p1 || s1_free);
    assign accept   = rd_valid && rd_ready;

    // ---- S1: bank storage and registered bank read -----------------------
    // Read and write share one clocked process per bank, so a read of the
    // word being written in the same cycle returns the previous contents.
    for (genvar j = 0; j < NBANK; j++) begin : g_bank
        localparam int LANE = j % LANES;

        logic [WORD_W-1:0] mem [DEPTH];
        logic [WORD_W-1:0] word_p1;

        always_ff @(posedge clk) begin
            if (wr_en && wr_bank_sel[j] && wr_in_range) begin
                mem[wr_addr] <= wr_data[LANE*WORD_W +: WORD_W];
            end
            if (accept) begin
                word_p1 <= rd_in_range ? mem[rd_addr] : '0;
            end
        end

        assign words_p1[j*WORD_W +: WORD_W] = word_p1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s1_free) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_p1 <= norm_mode(rd_mode);
            row_p1  <= rd_row;
        end
    end

    // Transpose bank-major words into output rows: output row r is pixel r
    // of every bank, bank 0 in the least significant position.
    always_comb begin
        block_p1 = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j < NBANK; j++) begin
                block_p1[(r*NBANK + j)*PIXEL +: PIXEL] = words_p1[(j*ROWS + r)*PIXEL +: PIXEL];
            end
        end
    end

    // Row picked for row-mode beats: the burst counter while bursting,
    // otherwise the requested row (single-row) or row 0 (burst start).
    always_comb begin
        sel_row = '0;
        if (state == ST_BURST) begin
            sel_row = cnt;
        end else if (mode_p1 == MODE_ROW) begin
            sel_row = row_p1;
        end
        row_sel_data = block_p1[int'(sel_row)*ROW_W +: ROW_W];
    end

    // ---- S2: output FSM and output register -------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        row_nxt   = out_row;
        data_nxt  = out_data;
        s1_free   = 1'b0;

        if (adv2) begin
            case (state)
                ST_IDLE: begin
                    if (vld_p1) begin
                        valid_nxt = 1'b1;
                        if (mode_p1 == MODE_BURST) begin
                            // First beat of a burst; S1 stays occupied
                            // until the final row has been issued.
                            data_nxt                = '0;
                            data_nxt[ROW_W-1:0]     = row_sel_data;
                            row_nxt                 = '0;
                            last_nxt                = 1'b0;
                            cnt_nxt                 = RW'(1);
                            state_nxt               = ST_BURST;
                        end else if (mode_p1 == MODE_ROW) begin
                            data_nxt                = '0;
                            data_nxt[ROW_W-1:0]     = row_sel_data;
                            row_nxt                 = row_p1;
                            last_nxt                = 1'b1;
                            s1_free                 = 1'b1;
                        end else begin
                            data_nxt                = block_p1;
                            row_nxt                 = '0;
                            last_nxt                = 1'b1;
                            s1_free                 = 1'b1;
                        end
                    end else begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end
                end

                ST_BURST: begin
                    valid_nxt            = 1'b1;
                    data_nxt             = '0;
                    data_nxt[ROW_W-1:0]  = row_sel_data;
                    row_nxt              = cnt;
                    if (cnt == LAST_ROW) begin
                        last_nxt  = 1'b1;
                        s1_free   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        last_nxt  = 1'b0;
                        cnt_nxt   = cnt + RW'(1);
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output data is cleared on reset as well, so a dropped request leaves
    // no stale pixels on the bus.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
            out_row   <= row_nxt;
            out_data  <= data_nxt;
        end
    end

endmodule

// File: tb/tb_ref_bank_mem_p.sv
// ---------------------------------------------------------------------------
// tb_ref_bank_mem_p
//
// Self-checking bench for ref_bank_mem_p. Directed scenarios check latency,
// layout, burst sequencing, read-during-write and reset; a randomized run
// compares every output beat against a pixel-array reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ref_bank_mem_p;

    localparam int PIXEL = 8;
    localparam int NBANK = 32;
    localparam int ROWS  = 8;
    localparam int DEPTH = 96;
    localparam int AW    = 7;
    localparam int LANES = 4;
    localparam int RW    = 3;
    localparam int WORD_W = ROWS * PIXEL;
    localparam int ROW_W  = NBANK * PIXEL;
    localparam int BLK_W  = NBANK * WORD_W;
    localparam int WR_W   = LANES * WORD_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_en = 1'b0;
    logic [NBANK-1:0]  wr_bank_sel = '0;
    logic [AW-1:0]     wr_addr = '0;
    logic [WR_W-1:0]   wr_data = '0;
    logic              rd_valid = 1'b0;
    logic              rd_ready;
    logic [AW-1:0]     rd_addr = '0;
    logic [1:0]        rd_mode = '0;
    logic [RW-1:0]     rd_row = '0;
    logic [BLK_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [RW-1:0]     out_row;
    logic              out_last;

    ref_bank_mem_p dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_bank_sel (wr_bank_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .rd_mode     (rd_mode),
        .rd_row      (rd_row),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BLK_W-1:0] data;
        logic [RW-1:0]    row;
        logic             last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      got_q[$];
    logic [7:0] pix [NBANK][DEPTH][ROWS];
    int         total = 0;
    int         bad = 0;
    int         stall_bad = 0;
    logic       stall_pend = 1'b0;
    beat_t      stall_beat;

    // ---------------- reference model ----------------
    function automatic logic [BLK_W-1:0] model_row(input int a, input int r);
        logic [BLK_W-1:0] v = '0;
        if (a < DEPTH)
            for (int j = 0; j < NBANK; j++) v[j*PIXEL +: PIXEL] = pix[j][a][r];
        return v;
    endfunction

    function automatic logic [BLK_W-1:0] model_block(input int a);
        logic [BLK_W-1:0] v = '0;
        if (a < DEPTH)
            for (int r = 0; r < ROWS; r++)
                for (int j = 0; j < NBANK; j++)
                    v[(r*NBANK + j)*PIXEL +: PIXEL] = pix[j][a][r];
        return v;
    endfunction

    function automatic void model_write(input logic [NBANK-1:0] sel, input int a,
                                        input logic [WR_W-1:0] d);
        if (a < DEPTH)
            for (int j = 0; j < NBANK; j++)
                if (sel[j])
                    for (int r = 0; r < ROWS; r++)
                        pix[j][a][r] = d[((j % LANES)*ROWS + r)*PIXEL +: PIXEL];
    endfunction

    function automatic void push_expected(input logic [1:0] m, input int a, input int r);
        beat_t b;
        if (m == 2'd1) begin
            b.data = model_row(a, r); b.row = RW'(r); b.last = 1'b1; exp_q.push_back(b);
        end else if (m == 2'd2) begin
            for (int k = 0; k < ROWS; k++) begin
                b.data = model_row(a, k); b.row = RW'(k); b.last = (k == ROWS-1);
                exp_q.push_back(b);
            end
        end else begin
            b.data = model_block(a); b.row = '0; b.last = 1'b1; exp_q.push_back(b);
        end
    endfunction

    // Directed-test expectations: bank j pixel r = j*8+r.
    function automatic logic [BLK_W-1:0] pat_row(input int r);
        logic [BLK_W-1:0] v = '0;
        for (int j = 0; j < NBANK; j++) v[j*PIXEL +: PIXEL] = 8'(j*8 + r);
        return v;
    endfunction

    function automatic logic [BLK_W-1:0] pat_block();
        logic [BLK_W-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < NBANK; j++) v[(r*NBANK + j)*PIXEL +: PIXEL] = 8'(j*8 + r);
        return v;
    endfunction

    // Lowest differing byte, for compact failure messages.
    function automatic int diff_byte(input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] b);
        for (int i = 0; i < BLK_W/8; i++) if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return -1;
    endfunction

    function automatic logic [WR_W-1:0] rand_wr();
        logic [WR_W-1:0] v;
        for (int i = 0; i < WR_W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- monitor: model update and beat capture ----------------
    always @(negedge clk) begin
        beat_t b;
        if (stall_pend && !rst_n) begin
            if (!out_valid || out_data !== stall_beat.data || out_row !== stall_beat.row ||
                out_last !== stall_beat.last) stall_bad++;
        end
        stall_pend = !rst_n && out_valid && !out_ready;
        stall_beat.data = out_data;
        stall_beat.row  = out_row;
        stall_beat.last = out_last;
        if (rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                b.data = out_data; b.row = out_row; b.last = out_last;
                got_q.push_back(b);
            end
            if (rd_valid && rd_ready) push_expected(rd_mode, int'(rd_addr), int'(rd_row));
        end
        if (wr_en) model_write(wr_bank_sel, int'(wr_addr), wr_data);
    end

    // ---------------- driver helpers (called at posedge+1) ----------------
    task automatic do_write(input logic [NBANK-1:0] sel, input int a, input logic [WR_W-1:0] d);
        wr_en = 1'b1; wr_bank_sel = sel; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [1:0] m, input int a, input int r);
        int n = 0;
        rd_valid = 1'b1; rd_mode = m; rd_addr = AW'(a); rd_row = RW'(r);
        @(negedge clk);
        while (!rd_ready && n < 50) begin @(negedge clk); n++; end
        if (!rd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout got rd_ready=%b want=1", rd_ready);
        end
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic clear_q();
        exp_q.delete(); got_q.delete(); stall_bad = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++; if (out_row !== '0) begin bad++; $display("FAIL rst_out_row got=%0d want=0", out_row); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data byte=%0d want all zero", diff_byte(out_data, '0)); end
        total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL rst_rd_ready got=%b want=0", rd_ready); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_rd_ready got=%b want=1", rd_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b want=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic fill_memory();
        for (int a = 0; a < DEPTH; a++) do_write('1, a, rand_wr());
        for (int j = 0; j < NBANK; j++) begin
            logic [WR_W-1:0] d = '0;
            for (int r = 0; r < ROWS; r++) d[((j % LANES)*ROWS + r)*PIXEL +: PIXEL] = 8'(j*8 + r);
            do_write(NBANK'(1) << j, 5, d);
        end
    endtask

    task automatic test_block();
        out_ready = 1'b1;
        send(2'd0, 5, 0);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL block_early_valid got=%b want=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL block_latency got=%b want=1", out_valid); end
        total++; if (out_data !== pat_block()) begin bad++; $display("FAIL block_data byte=%0d got=%h want=%h", diff_byte(out_data, pat_block()), out_data[diff_byte(out_data, pat_block())*8 +: 8], pat_block() >> (diff_byte(out_data, pat_block())*8) & 8'hFF); end
        total++; if (out_last !== 1'b1) begin bad++; $display("FAIL block_last got=%b want=1", out_last); end
        total++; if (out_row !== '0) begin bad++; $display("FAIL block_row got=%0d want=0", out_row); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_row();
        out_ready = 1'b1;
        send(2'd1, 5, 3);
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL row_valid got=%b want=1", out_valid); end
        total++; if (out_data !== pat_row(3)) begin bad++; $display("FAIL row_data byte=%0d differs", diff_byte(out_data, pat_row(3))); end
        total++; if (out_row !== RW'(3)) begin bad++; $display("FAIL row_index got=%0d want=3", out_row); end
        total++; if (out_last !== 1'b1) begin bad++; $display("FAIL row_last got=%b want=1", out_last); end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        logic [BLK_W-1:0] od [12];
        logic [RW-1:0]    orow [12];
        logic             ov [12];
        logic             ol [12];
        logic             rdy [12];
        int               acc_i = -1;
        int               low_cnt = 0;
        out_ready = 1'b1;
        send(2'd2, 5, 0);
        // Second request queued behind the burst.
        rd_valid = 1'b1; rd_mode = 2'd0; rd_addr = AW'(5);
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            od[i] = out_data; orow[i] = out_row; ov[i] = out_valid; ol[i] = out_last; rdy[i] = rd_ready;
            if (rd_valid && rd_ready && acc_i < 0) acc_i = i;
            @(posedge clk); #1;
            if (acc_i == i) rd_valid = 1'b0;
        end
        for (int i = 1; i < 12 && !rdy[i]; i++) low_cnt++;
        total++; if (low_cnt != 7) begin bad++; $display("FAIL burst_ready_low got=%0d want=7", low_cnt); end
        total++; if (acc_i != 8) begin bad++; $display("FAIL burst_next_accept got=%0d want=8", acc_i); end
        total++; if (ov[1] !== 1'b0) begin bad++; $display("FAIL burst_early_valid got=%b want=0", ov[1]); end
        for (int k = 0; k < ROWS; k++) begin
            total++;
            if (ov[k+2] !== 1'b1 || orow[k+2] !== RW'(k) || ol[k+2] !== (k == ROWS-1) || od[k+2] !== pat_row(k)) begin
                bad++;
                $display("FAIL burst_beat%0d got v=%b row=%0d last=%b byte=%0d want v=1 row=%0d last=%b",
                         k, ov[k+2], orow[k+2], ol[k+2], diff_byte(od[k+2], pat_row(k)), k, (k == ROWS-1));
            end
        end
        total++;
        if (ov[10] !== 1'b1 || ol[10] !== 1'b1 || orow[10] !== '0 || od[10] !== pat_block()) begin
            bad++;
            $display("FAIL burst_followon got v=%b last=%b row=%0d byte=%0d want v=1 last=1 row=0",
                     ov[10], ol[10], orow[10], diff_byte(od[10], pat_block()));
        end
    endtask

    task automatic test_back_to_back();
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        clear_q();
        rd_valid = 1'b1; rd_mode = 2'd0; rd_addr = '0;
        while ((idx < 4 || got_q.size() < 4) && cyc < 80) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            @(negedge clk);
            acc = rd_valid && rd_ready;
            @(posedge clk); #1;
            if (acc) begin idx++; rd_addr = AW'(idx); rd_valid = (idx < 4); end
            cyc++;
        end
        out_ready = 1'b1;
        rd_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        total++; if (got_q.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got_q.size()); end
        total++; if (exp_q.size() != 4) begin bad++; $display("FAIL b2b_model_count got=%0d want=4", exp_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].row !== exp_q[i].row || got_q[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL b2b_beat%0d got row=%0d last=%b byte=%0d want row=%0d last=%b",
                         i, got_q[i].row, got_q[i].last, diff_byte(got_q[i].data, exp_q[i].data), exp_q[i].row, exp_q[i].last);
            end
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL b2b_stall_hold got=%0d want=0", stall_bad); end
    endtask

    task automatic test_rw_same_cycle();
        logic [WR_W-1:0]  d = '0;
        logic [BLK_W-1:0] old_blk = '0;
        for (int l = 0; l < LANES; l++)
            for (int r = 0; r < ROWS; r++) d[(l*ROWS + r)*PIXEL +: PIXEL] = 8'(8'hA0 + l*8 + r);
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < NBANK; j++) old_blk[(r*NBANK + j)*PIXEL +: PIXEL] = 8'(8'hA0 + (j % LANES)*8 + r);
        out_ready = 1'b1;
        do_write('1, 9, d);
        wr_en = 1'b1; wr_bank_sel = '1; wr_addr = AW'(9); wr_data = '1;
        rd_valid = 1'b1; rd_mode = 2'd0; rd_addr = AW'(9);
        @(negedge clk);
        total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL rw_accept got=%b want=1", rd_ready); end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== old_blk) begin bad++; $display("FAIL rw_old_data got v=%b byte=%0d differs", out_valid, diff_byte(out_data, old_blk)); end
        @(posedge clk); #1;
        send(2'd0, 9, 0);
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== {BLK_W{1'b1}}) begin bad++; $display("FAIL rw_new_data got v=%b byte=%0d differs", out_valid, diff_byte(out_data, {BLK_W{1'b1}})); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        out_ready = 1'b1;
        send(2'd2, 5, 0);
        @(negedge clk);
        while (!(out_valid && out_row == RW'(4)) && n < 20) begin @(negedge clk); n++; end
        total++; if (out_row !== RW'(4)) begin bad++; $display("FAIL mid_burst_reach got=%0d want=4", out_row); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL midrst_rd_ready got=%b want=0", rd_ready); end
        total++; if (out_row !== '0 || out_last !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL midrst_outputs got row=%0d last=%b want row=0 last=0 data=0", out_row, out_last); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (rd_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_release got rdy=%b v=%b want rdy=1 v=0", rd_ready, out_valid); end
        @(posedge clk); #1;
        send(2'd0, 5, 0);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== pat_block()) begin
            bad++;
            $display("FAIL midrst_after got v=%b last=%b byte=%0d want v=1 last=1", out_valid, out_last, diff_byte(out_data, pat_block()));
        end
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        logic acc = 1'b0;
        int   n = 0;
        clear_q();
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!rd_valid || acc) begin
                rd_valid = (cyc < 260) && ($urandom % 3 != 0);
                rd_mode  = 2'($urandom);
                rd_addr  = AW'($urandom_range(0, 127));
                rd_row   = RW'($urandom);
            end
            wr_en       = ($urandom % 4 == 0);
            wr_bank_sel = NBANK'($urandom);
            wr_addr     = AW'($urandom_range(0, 127));
            wr_data     = rand_wr();
            out_ready   = ($urandom % 3 != 0);
            @(negedge clk);
            acc = rd_valid && rd_ready;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        out_ready = 1'b1;
        while (rd_valid && !acc && n < 50) begin
            @(negedge clk); acc = rd_valid && rd_ready; @(posedge clk); #1; n++;
        end
        rd_valid = 1'b0;
        repeat (30) begin @(posedge clk); #1; end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].row !== exp_q[i].row || got_q[i].last !== exp_q[i].last) begin
                bad++;
                $display("FAIL rand_beat%0d got row=%0d last=%b byte=%0d want row=%0d last=%b",
                         i, got_q[i].row, got_q[i].last, diff_byte(got_q[i].data, exp_q[i].data), exp_q[i].row, exp_q[i].last);
            end
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL rand_stall_hold got=%0d want=0", stall_bad); end
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_block();
        test_single_row();
        test_burst();
        test_back_to_back();
        test_rw_same_cycle();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
